// File: rtl/ram_sdp_wr_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ram_sdp_wr_ctrl_pkg
// Shared types and helpers for the dual-clock FIFO controllers built on the
// 32-bit simple-dual-port block-RAM wrapper.
//   - wr_ctrl_state_t : write-side controller states
//   - bin2gray/gray2bin : pointer code conversion
// The conversions work on the widest legal pointer (AddrWidth 10 + wrap bit).
// Callers zero-extend narrower pointers and truncate the result. Zero high bits
// do not disturb either conversion, so one function serves every width.
// ---------------------------------------------------------------------------
package ram_sdp_wr_ctrl_pkg;

  localparam int MaxPtrWidth = 11;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wr_ctrl_state_t;

  function automatic logic [MaxPtrWidth-1:0] bin2gray(input logic [MaxPtrWidth-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [MaxPtrWidth-1:0] gray2bin(input logic [MaxPtrWidth-1:0] gray);
    logic [MaxPtrWidth-1:0] bin;
    bin[MaxPtrWidth-1] = gray[MaxPtrWidth-1];
    for (int i = MaxPtrWidth - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/ram_sdp_wr_ctrl_ptr_sync.sv
// ---------------------------------------------------------------------------
// ptr_sync
// Width x Stages flop synchronizer for a Gray-coded pointer. It crosses into
// the clk domain and clears to 0 on reset. The read-side controller reuses it.
//   clk   : destination clock
//   reset : synchronous, active-high
//   din   : pointer from the foreign clock domain
//   dout  : pointer after Stages flops
// ---------------------------------------------------------------------------
module ptr_sync #(
  parameter int Width  = 10,
  parameter int Stages = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout
);

  // The first stage samples an asynchronous bus. ASYNC_REG keeps it packed
  // next to the following stage, which gives metastability time to settle.
  (* ASYNC_REG = "TRUE" *) logic [Width-1:0] meta_q;
  logic [Width-1:0] meta_d;
  logic [Width-1:0] tail_q [Stages-1];
  logic [Width-1:0] tail_d [Stages-1];

  always_comb begin
    meta_d    = din;
    tail_d[0] = meta_q;
    for (int i = 1; i < Stages - 1; i++) begin
      tail_d[i] = tail_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      tail_q <= '{default: '0};
    end else begin
      meta_q <= meta_d;
      tail_q <= tail_d;
    end
  end

  assign dout = tail_q[Stages-2];

endmodule

// File: rtl/ram_sdp_wr_ctrl.sv
// ---------------------------------------------------------------------------
// ram_sdp_wr_ctrl
// Write-side controller of a dual-clock FIFO over the 32-bit SDP block RAM.
// The whole controller runs in clk_wr.
//   clk_wr, reset        : write clock, synchronous active-high reset
//   s_data/s_valid/s_ready : incoming 32-bit stream
//   ram_wr_addr/_data/_valid/_ready : RAM write handshake
//   rd_ptr_gray          : read-side committed pointer (Gray, async domain)
//   wr_ptr_gray          : committed write pointer (Gray, registered)
//   full, level          : occupancy seen from the write side
// rsv_ptr counts words the controller has accepted. cmt_ptr counts words
// the RAM has finished writing. Only the committed count goes to the read
// side, so the reader never sees a slot before its data is in the RAM.
// ---------------------------------------------------------------------------
module ram_sdp_wr_ctrl
  import ram_sdp_wr_ctrl_pkg::*;
#(
  parameter int AddrWidth  = 9,
  parameter int SyncStages = 2
) (
  input  logic                 clk_wr,
  input  logic                 reset,
  input  logic [31:0]          s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [AddrWidth-1:0] ram_wr_addr,
  output logic [31:0]          ram_wr_data,
  output logic                 ram_wr_valid,
  input  logic                 ram_wr_ready,
  input  logic [AddrWidth:0]   rd_ptr_gray,
  output logic [AddrWidth:0]   wr_ptr_gray,
  output logic                 full,
  output logic [AddrWidth:0]   level
);

  localparam int PtrWidth = AddrWidth + 1;
  localparam logic [PtrWidth-1:0] FullLevel = {1'b1, {AddrWidth{1'b0}}};

  wr_ctrl_state_t      state_q, state_d;
  logic [PtrWidth-1:0] rsv_ptr_q, rsv_ptr_d;
  logic [PtrWidth-1:0] cmt_ptr_q, cmt_ptr_d;
  logic [31:0]         data_q, data_d;
  logic [PtrWidth-1:0] wr_ptr_gray_q, wr_ptr_gray_d;
  logic [PtrWidth-1:0] rd_gray_sync;
  logic [PtrWidth-1:0] rd_bin;
  logic                s_ready_c;

  ptr_sync #(
    .Width  (PtrWidth),
    .Stages (SyncStages)
  ) u_rd_ptr_sync (
    .clk   (clk_wr),
    .reset (reset),
    .din   (rd_ptr_gray),
    .dout  (rd_gray_sync)
  );

  assign rd_bin = PtrWidth'(gray2bin(MaxPtrWidth'(rd_gray_sync)));

  // Level uses the reserved pointer, so an in-flight word already holds its
  // slot. The wrap bit makes level == depth mean full rather than empty.
  assign level = rsv_ptr_q - rd_bin;
  assign full  = (level == FullLevel);

  // In WRITE, a completing RAM write frees the controller for a new word in
  // the same cycle. This gives back-to-back transfers at one word per cycle.
  always_comb begin
    state_d      = state_q;
    rsv_ptr_d    = rsv_ptr_q;
    cmt_ptr_d    = cmt_ptr_q;
    data_d       = data_q;
    s_ready_c    = 1'b0;
    ram_wr_valid = 1'b0;
    case (state_q)
      IDLE: begin
        s_ready_c = !full;
        if (s_valid && s_ready_c) begin
          data_d    = s_data;
          rsv_ptr_d = rsv_ptr_q + PtrWidth'(1);
          state_d   = WRITE;
        end
      end
      WRITE: begin
        ram_wr_valid = 1'b1;
        if (ram_wr_ready) begin
          cmt_ptr_d = cmt_ptr_q + PtrWidth'(1);
          s_ready_c = !full;
          if (s_valid && s_ready_c) begin
            data_d    = s_data;
            rsv_ptr_d = rsv_ptr_q + PtrWidth'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    wr_ptr_gray_d = PtrWidth'(bin2gray(MaxPtrWidth'(cmt_ptr_d)));
  end

  always_ff @(posedge clk_wr) begin
    if (reset) begin
      state_q       <= IDLE;
      rsv_ptr_q     <= '0;
      cmt_ptr_q     <= '0;
      data_q        <= '0;
      wr_ptr_gray_q <= '0;
    end else begin
      state_q       <= state_d;
      rsv_ptr_q     <= rsv_ptr_d;
      cmt_ptr_q     <= cmt_ptr_d;
      data_q        <= data_d;
      wr_ptr_gray_q <= wr_ptr_gray_d;
    end
  end

  // Keep the stream closed while reset is high. The state is about to clear,
  // so any word taken now would be lost.
  assign s_ready     = s_ready_c && !reset;
  assign ram_wr_addr = cmt_ptr_q[AddrWidth-1:0];
  assign ram_wr_data = data_q;
  assign wr_ptr_gray = wr_ptr_gray_q;

endmodule

// File: tb/tb_ram_sdp_wr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_sdp_wr_ctrl
// Bench for ram_sdp_wr_ctrl with AddrWidth=4 and SyncStages=2.
// A reference model tracks the design at the transaction level:
//   - counts of accepted and committed words
//   - a queue of words waiting for the RAM
//   - the read-pointer history that sets the synchronized view
// Every clk_wr cycle goes through applyStimulus. That task drives inputs
// just after the rising edge, then compares outputs with the model on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_ram_sdp_wr_ctrl;

  localparam int AW    = 4;
  localparam int SS    = 2;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;
  localparam int PMOD  = 1 << PW;

  logic          clk_wr = 1'b0;
  logic          reset;
  logic [31:0]   s_data;
  logic          s_valid;
  logic          s_ready;
  logic [AW-1:0] ram_wr_addr;
  logic [31:0]   ram_wr_data;
  logic          ram_wr_valid;
  logic          ram_wr_ready;
  logic [AW:0]   rd_ptr_gray;
  logic [AW:0]   wr_ptr_gray;
  logic          full;
  logic [AW:0]   level;

  int checks = 0;
  int errors = 0;

  int          rsv_cnt = 0;
  int          cmt_cnt = 0;
  int          rd_cnt  = 0;
  logic [31:0] word_q[$];
  int          rd_hist[$];

  always #5 clk_wr = ~clk_wr;

  ram_sdp_wr_ctrl #(
    .AddrWidth  (AW),
    .SyncStages (SS)
  ) dut (
    .clk_wr       (clk_wr),
    .reset        (reset),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .ram_wr_addr  (ram_wr_addr),
    .ram_wr_data  (ram_wr_data),
    .ram_wr_valid (ram_wr_valid),
    .ram_wr_ready (ram_wr_ready),
    .rd_ptr_gray  (rd_ptr_gray),
    .wr_ptr_gray  (wr_ptr_gray),
    .full         (full),
    .level        (level)
  );

  function automatic logic [PW-1:0] toGray(input int n);
    logic [PW-1:0] b;
    b = PW'(n % PMOD);
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic clearModel();
    rsv_cnt = 0;
    cmt_cnt = 0;
    rd_cnt  = 0;
    word_q.delete();
    rd_hist.delete();
    for (int i = 0; i <= SS; i++) rd_hist.push_back(0);
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic rdy,
                               input logic rd_step, input logic rst);
    int   rd_sync;
    int   lvl;
    logic exp_full;
    logic pend;
    logic exp_rdy;
    @(posedge clk_wr);
    #1;
    if (rd_step && rd_cnt < cmt_cnt) rd_cnt++;
    if (rst) rd_cnt = 0;
    reset        = rst;
    s_valid      = v;
    s_data       = d;
    ram_wr_ready = rdy;
    rd_ptr_gray  = toGray(rd_cnt);
    rd_hist.push_back(rd_cnt);
    if (rd_hist.size() > SS + 1) void'(rd_hist.pop_front());
    @(negedge clk_wr);
    if (rst) begin
      checkOutput("s_ready_in_reset", 32'(s_ready), 32'd0);
      clearModel();
      return;
    end
    rd_sync  = rd_hist[rd_hist.size() - 1 - SS];
    lvl      = rsv_cnt - rd_sync;
    exp_full = (lvl == DEPTH);
    pend     = (rsv_cnt != cmt_cnt);
    exp_rdy  = !exp_full && (!pend || rdy);
    checkOutput("level", 32'(level), 32'(lvl));
    checkOutput("full", 32'(full), 32'(exp_full));
    checkOutput("s_ready", 32'(s_ready), 32'(exp_rdy));
    checkOutput("ram_wr_valid", 32'(ram_wr_valid), 32'(pend));
    checkOutput("wr_ptr_gray", 32'(wr_ptr_gray), 32'(toGray(cmt_cnt)));
    if (pend) begin
      checkOutput("ram_wr_addr", 32'(ram_wr_addr), 32'(cmt_cnt % DEPTH));
      checkOutput("ram_wr_data", ram_wr_data, word_q[0]);
    end
    if (pend && rdy) begin
      cmt_cnt++;
      void'(word_q.pop_front());
    end
    if (v && exp_rdy) begin
      rsv_cnt++;
      word_q.push_back(d);
    end
  endtask

  initial begin
    reset        = 1'b1;
    s_valid      = 1'b0;
    s_data       = '0;
    ram_wr_ready = 1'b0;
    rd_ptr_gray  = '0;
    clearModel();

    $display("[TB] reset");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_addr", 32'(ram_wr_addr), 32'd0);
    checkOutput("rst_data", ram_wr_data, 32'd0);
    checkOutput("rst_full", 32'(full), 32'd0);

    $display("[TB] three back-to-back words");
    applyStimulus(1'b1, 32'hA0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hA1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hA2, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("t1_gray", 32'(wr_ptr_gray), 32'b00010);
    checkOutput("t1_level", 32'(level), 32'd3);

    $display("[TB] fill to full");
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0, 1'b0);
    checkOutput("t2_full", 32'(full), 32'd1);
    checkOutput("t2_level", 32'(level), 32'd16);
    checkOutput("t2_s_ready", 32'(s_ready), 32'd0);
    checkOutput("t2_no_write", 32'(ram_wr_valid), 32'd0);

    $display("[TB] read side frees four slots");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("t3_full", 32'(full), 32'd0);
    checkOutput("t3_level", 32'(level), 32'd12);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0, 1'b0);
    checkOutput("t3_refull", 32'(full), 32'd1);
    checkOutput("t3_gray", 32'(wr_ptr_gray), 32'(toGray(20)));

    $display("[TB] RAM stall");
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_data", ram_wr_data, 32'hDEADBEEF);
    checkOutput("t4_valid", 32'(ram_wr_valid), 32'd1);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'(($urandom % 4) != 0), $urandom, 1'(($urandom % 3) != 0),
                    1'(($urandom % 2) != 0), 1'b0);
    end

    $display("[TB] reset during WRITE");
    applyStimulus(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_valid", 32'(ram_wr_valid), 32'd0);
    checkOutput("t6_gray", 32'(wr_ptr_gray), 32'd0);
    checkOutput("t6_level", 32'(level), 32'd0);

    $display("[TB] 40 writes with wrap");
    for (int i = 0; i < 200; i++) begin
      if (cmt_cnt >= 40) break;
      applyStimulus(1'(rsv_cnt < 40), 32'hC000_0000 + 32'(rsv_cnt), 1'b1, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_gray", 32'(wr_ptr_gray), 32'b01100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
